// File: rtl/lap_buffer_if.sv
// Port bundle between the stopwatch datapath/display mux and the lap recorder.
interface lap_buffer_if #(
  parameter int unsigned DEPTH = 8
);
  localparam int unsigned IDX_W = $clog2(DEPTH);

  logic             lap;
  logic             clear;
  logic             mode;
  logic [15:0]      time_in;
  logic [IDX_W-1:0] rd_idx;
  logic [15:0]      rd_data;
  logic             rd_valid;
  logic [IDX_W:0]   lap_count;
  logic             overflow;
  logic [15:0]      best_lap;
  logic             best_valid;

  modport master (
    output lap, clear, mode, time_in, rd_idx,
    input  rd_data, rd_valid, lap_count, overflow, best_lap, best_valid
  );

  modport slave (
    input  lap, clear, mode, time_in, rd_idx,
    output rd_data, rd_valid, lap_count, overflow, best_lap, best_valid
  );
endinterface

// File: rtl/lap_buffer.sv
// Lap-time recorder: newest-first history of BCD splits or lap deltas,
// fastest-lap tracking and a registered random-access read port.
module lap_buffer #(
  parameter int unsigned DEPTH = 8
) (
  input logic        clk,
  input logic        rstn,
  lap_buffer_if.slave bus
);
  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = IDX_W + 1;

  logic [15:0]      hist_q [DEPTH];
  logic [15:0]      hist_d [DEPTH];
  logic [15:0]      prev_q, prev_d;
  logic             lap_q, lap_d;
  logic [CNT_W-1:0] lap_count_q, lap_count_d;
  logic             overflow_q, overflow_d;
  logic [15:0]      best_lap_q, best_lap_d;
  logic             best_valid_q, best_valid_d;
  logic [15:0]      rd_data_q, rd_data_d;
  logic             rd_valid_q, rd_valid_d;

  logic             capture;
  logic [15:0]      delta;

  // Mixed-radix BCD subtract a - b, digit radices 10/6/10/10 from the top,
  // final borrow dropped so the 9:59.9 wrap yields a modulo-10:00.0 delta.
  function automatic logic [15:0] bcd_sub(input logic [15:0] a, input logic [15:0] b);
    logic [15:0] r;
    logic        borrow;
    logic [4:0]  d;
    logic [4:0]  radix;
    r      = '0;
    borrow = 1'b0;
    for (int unsigned i = 0; i < 4; i++) begin
      radix = (i == 2) ? 5'd6 : 5'd10;
      d     = 5'(a[4*i +: 4]) - 5'(b[4*i +: 4]) - 5'(borrow);
      if (d[4]) begin
        d      = d + radix;
        borrow = 1'b1;
      end else begin
        borrow = 1'b0;
      end
      r[4*i +: 4] = d[3:0];
    end
    return r;
  endfunction

  assign capture = bus.lap & ~lap_q & ~bus.clear;
  assign delta   = bcd_sub(bus.time_in, prev_q);

  always_comb begin
    hist_d       = hist_q;
    prev_d       = prev_q;
    lap_d        = bus.lap;
    lap_count_d  = lap_count_q;
    overflow_d   = overflow_q;
    best_lap_d   = best_lap_q;
    best_valid_d = best_valid_q;
    rd_data_d    = '0;
    rd_valid_d   = (CNT_W'(bus.rd_idx) < lap_count_q);

    // Read mux works from current storage; an in-range index is always < DEPTH.
    for (int unsigned k = 0; k < DEPTH; k++) begin
      if (rd_valid_d && (IDX_W'(k) == bus.rd_idx)) rd_data_d = hist_q[k];
    end

    if (bus.clear) begin
      for (int unsigned k = 0; k < DEPTH; k++) hist_d[k] = '0;
      prev_d       = '0;
      lap_count_d  = '0;
      overflow_d   = 1'b0;
      best_lap_d   = '0;
      best_valid_d = 1'b0;
    end else if (capture) begin
      hist_d[0] = bus.mode ? delta : bus.time_in;
      for (int unsigned k = 1; k < DEPTH; k++) hist_d[k] = hist_q[k-1];
      prev_d = bus.time_in;
      if (lap_count_q == CNT_W'(DEPTH)) overflow_d  = 1'b1;
      else                              lap_count_d = lap_count_q + CNT_W'(1);
      if (!best_valid_q || (delta < best_lap_q)) begin
        best_lap_d   = delta;
        best_valid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int unsigned k = 0; k < DEPTH; k++) hist_q[k] <= '0;
      prev_q       <= '0;
      lap_q        <= 1'b0;
      lap_count_q  <= '0;
      overflow_q   <= 1'b0;
      best_lap_q   <= '0;
      best_valid_q <= 1'b0;
      rd_data_q    <= '0;
      rd_valid_q   <= 1'b0;
    end else begin
      hist_q       <= hist_d;
      prev_q       <= prev_d;
      lap_q        <= lap_d;
      lap_count_q  <= lap_count_d;
      overflow_q   <= overflow_d;
      best_lap_q   <= best_lap_d;
      best_valid_q <= best_valid_d;
      rd_data_q    <= rd_data_d;
      rd_valid_q   <= rd_valid_d;
    end
  end

  assign bus.rd_data    = rd_data_q;
  assign bus.rd_valid   = rd_valid_q;
  assign bus.lap_count  = lap_count_q;
  assign bus.overflow   = overflow_q;
  assign bus.best_lap   = best_lap_q;
  assign bus.best_valid = best_valid_q;
endmodule

// File: tb/tb_lap_buffer.sv
// Self-checking bench for lap_buffer: time-in-tenths reference model plus a
// read-port scoreboard queue.
module tb_lap_buffer;
  localparam int unsigned DEPTH = 8;

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  lap_buffer_if #(.DEPTH(DEPTH)) bus ();
  lap_buffer #(.DEPTH(DEPTH)) dut (.clk(clk), .rstn(rstn), .bus(bus));

  int n_tests = 0;
  int n_fail  = 0;

  // Reference state
  logic [15:0] m_hist [DEPTH];
  logic [15:0] m_prev;
  int          m_count;
  logic        m_ovf;
  logic [15:0] m_best;
  logic        m_best_valid;

  logic [16:0] sb_q [$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic int to_tenths(input logic [15:0] v);
    return int'(v[15:12]) * 600 + int'(v[11:8]) * 100 + int'(v[7:4]) * 10 + int'(v[3:0]);
  endfunction

  function automatic logic [15:0] from_tenths(input int v);
    logic [15:0] r;
    int          x;
    x = v;
    r[15:12] = 4'(x / 600); x = x % 600;
    r[11:8]  = 4'(x / 100); x = x % 100;
    r[7:4]   = 4'(x / 10);
    r[3:0]   = 4'(x % 10);
    return r;
  endfunction

  task automatic model_clear();
    for (int k = 0; k < DEPTH; k++) m_hist[k] = '0;
    m_prev = '0; m_count = 0; m_ovf = 1'b0; m_best = '0; m_best_valid = 1'b0;
  endtask

  task automatic model_capture(input logic [15:0] t, input logic md);
    logic [15:0] dl;
    dl = from_tenths((to_tenths(t) - to_tenths(m_prev) + 6000) % 6000);
    for (int k = DEPTH - 1; k > 0; k--) m_hist[k] = m_hist[k-1];
    m_hist[0] = md ? dl : t;
    m_prev = t;
    if (m_count == DEPTH) m_ovf = 1'b1; else m_count++;
    if (!m_best_valid || dl < m_best) begin m_best = dl; m_best_valid = 1'b1; end
  endtask

  task automatic do_lap(input logic [15:0] t, input logic md);
    @(posedge clk); #1;
    bus.time_in = t; bus.mode = md; bus.lap = 1'b1;
    @(posedge clk); #1;
    bus.lap = 1'b0;
    model_capture(t, md);
  endtask

  task automatic do_clear();
    @(posedge clk); #1;
    bus.clear = 1'b1;
    @(posedge clk); #1;
    bus.clear = 1'b0;
    model_clear();
  endtask

  // Drive an index, push the model's answer, pop and compare one cycle later.
  task automatic read_chk(input string tag, input int idx);
    logic [16:0] e;
    logic        v;
    @(posedge clk); #1;
    bus.rd_idx = 3'(idx);
    v = (idx < m_count);
    sb_q.push_back({v, v ? m_hist[idx] : 16'h0000});
    @(posedge clk); #1;
    e = sb_q.pop_front();
    check({tag, "_valid"}, 32'(bus.rd_valid), 32'(e[16]));
    check({tag, "_data"},  32'(bus.rd_data),  32'(e[15:0]));
  endtask

  task automatic status_chk(input string tag);
    check({tag, "_count"},      32'(bus.lap_count),  32'(m_count));
    check({tag, "_ovf"},        32'(bus.overflow),   32'(m_ovf));
    check({tag, "_best"},       32'(bus.best_lap),   32'(m_best));
    check({tag, "_best_valid"}, 32'(bus.best_valid), 32'(m_best_valid));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rstn = 1'b0;
    bus.lap = 1'b0; bus.clear = 1'b0; bus.mode = 1'b0;
    bus.time_in = '0; bus.rd_idx = '0;
    model_clear();
    repeat (2) @(posedge clk);
    @(negedge clk); rstn = 1'b1;
    #1;
    check("rst_rd_valid", 32'(bus.rd_valid), 32'd0);
    check("rst_rd_data",  32'(bus.rd_data),  32'd0);
    status_chk("rst");

    // Split history
    do_lap(16'h0123, 1'b0);
    do_lap(16'h0300, 1'b0);
    do_lap(16'h1045, 1'b0);
    check("split_e0_const", 32'(m_hist[0]), 32'h1045);
    for (int i = 0; i < 4; i++) read_chk($sformatf("split_idx%0d", i), i);
    status_chk("split");

    // Lap deltas and best lap
    do_clear();
    do_lap(16'h0123, 1'b1);
    do_lap(16'h0300, 1'b1);
    do_lap(16'h0400, 1'b1);
    for (int i = 0; i < 3; i++) read_chk($sformatf("delta_idx%0d", i), i);
    check("delta_best", 32'(bus.best_lap), 32'h0100);
    status_chk("delta");

    // Wrap across 9:59.9
    do_clear();
    do_lap(16'h9580, 1'b1);
    do_lap(16'h0015, 1'b1);
    read_chk("wrap_idx0", 0);
    check("wrap_e0", 32'(bus.rd_data), 32'h0035);

    // Overflow with 10 captures of 1..10 tenths
    do_clear();
    for (int i = 1; i <= 10; i++) do_lap(from_tenths(i), 1'b0);
    read_chk("ovf_idx0", 0);
    check("ovf_e0", 32'(bus.rd_data), 32'h0010);
    read_chk("ovf_idx7", 7);
    check("ovf_e7", 32'(bus.rd_data), 32'h0003);
    check("ovf_flag", 32'(bus.overflow), 32'd1);
    status_chk("ovf");

    // Held lap gives one capture
    do_clear();
    @(posedge clk); #1;
    bus.time_in = 16'h0042; bus.mode = 1'b0; bus.lap = 1'b1;
    repeat (20) @(posedge clk);
    #1; bus.lap = 1'b0;
    model_capture(16'h0042, 1'b0);
    check("hold_count", 32'(bus.lap_count), 32'd1);
    status_chk("hold");

    // Fill past overflow, then a lap edge coincident with clear is lost
    for (int i = 0; i < 9; i++) do_lap(16'h0100 + 16'(i), 1'b1);
    status_chk("pre_clr");
    @(posedge clk); #1;
    bus.lap = 1'b1; bus.clear = 1'b1; bus.time_in = 16'h0500;
    @(posedge clk); #1;
    bus.lap = 1'b0; bus.clear = 1'b0;
    model_clear();
    check("clr_count", 32'(bus.lap_count), 32'd0);
    status_chk("clr");
    read_chk("clr_idx0", 0);

    // Async reset between edges with 5 entries stored
    for (int i = 1; i <= 5; i++) do_lap(16'h0200 + 16'(i), 1'b0);
    read_chk("prerst_idx0", 0);
    @(posedge clk); #3;
    rstn = 1'b0;
    #1;
    model_clear();
    check("arst_rd_valid", 32'(bus.rd_valid), 32'd0);
    check("arst_rd_data",  32'(bus.rd_data),  32'd0);
    status_chk("arst");
    @(negedge clk); rstn = 1'b1;
    do_lap(16'h0050, 1'b1);
    read_chk("post_rst_idx0", 0);
    check("post_rst_e0", 32'(bus.rd_data), 32'h0050);
    status_chk("post_rst");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
